// File: rtl/if_fetch_unit_if.sv
// Instruction-bus bundle between the fetch unit (master) and the memory side (slave).
// One outstanding request: req/addr handshake with gnt, response on rvld/rdata.
interface if_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvld;
    logic [31:0] rdata;

    modport master (output req, addr, input gnt, rvld, rdata);
    modport slave  (input req, addr, output gnt, rvld, rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one fetch at a time and applies branch/trap redirects.
// Optional IF_FETCH_MISALIGN_EN: misaligned redirect targets present a flagged NOP instead of fetching.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_stall,
    input  logic                 i_x_branch_taken,
    input  logic [31:0]          i_x_branch_addr,
    input  logic                 i_clint_assert,
    input  logic [31:0]          i_clint_int_addr,
    if_fetch_unit_if.master      bus,
    output logic                 o_bus_if_halt,
    output logic                 o_if_vld,
    output logic [31:0]          o_if_pc,
`ifdef IF_FETCH_MISALIGN_EN
    output logic                 o_if_misalign,
`endif
    output logic [31:0]          o_if_insn
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_KILL} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        park_q, park_d;
    logic        buf_vld_q, buf_vld_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_insn_q, buf_insn_d;
    logic        if_vld_q, if_vld_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_insn_q, if_insn_d;

    logic        redir;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic        tgt_misalign;
    logic        accept;

    assign redir      = i_clint_assert | i_x_branch_taken;
    assign target_raw = i_clint_assert ? i_clint_int_addr : i_x_branch_addr;

`ifdef IF_FETCH_MISALIGN_EN
    assign tgt_misalign = redir && (target_raw[1:0] != 2'b00);
    assign target       = tgt_misalign ? target_raw : (target_raw & 32'hFFFF_FFFC);
`else
    assign tgt_misalign = 1'b0;
    assign target       = target_raw & 32'hFFFF_FFFC;
`endif

    // A response is only taken in WAIT; anything arriving in IDLE or KILL is stale.
    assign accept = (state_q == ST_WAIT) && bus.rvld && !redir;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            park_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            park_q  <= park_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        park_d  = park_q;
        if (redir) begin
            pc_d   = target;
            park_d = tgt_misalign;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (redir)
                    state_d = tgt_misalign ? ST_IDLE : ST_REQ;
                else if (!i_stall && !buf_vld_q && !park_q)
                    state_d = ST_REQ;
            end
            ST_REQ: begin
                if (redir)
                    state_d = bus.gnt ? ST_KILL : (tgt_misalign ? ST_IDLE : ST_REQ);
                else if (bus.gnt)
                    state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (redir) begin
                    if (bus.rvld) state_d = tgt_misalign ? ST_IDLE : ST_REQ;
                    else          state_d = ST_KILL;
                end else if (bus.rvld) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = i_stall ? ST_IDLE : ST_REQ;
                end
            end
            ST_KILL: begin
                // A redirect landing with the stale response still leaves KILL toward the new target.
                if (bus.rvld)
                    state_d = (i_stall || park_d) ? ST_IDLE : ST_REQ;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req       = (state_q == ST_REQ);
        bus.addr      = pc_q;
        o_bus_if_halt = (state_q == ST_REQ) ||
                        ((state_q == ST_WAIT) && !bus.rvld) ||
                        (state_q == ST_KILL);
    end

    always_comb begin
        buf_vld_d  = buf_vld_q;
        buf_pc_d   = buf_pc_q;
        buf_insn_d = buf_insn_q;
        if_vld_d   = if_vld_q;
        if_pc_d    = if_pc_q;
        if_insn_d  = if_insn_q;
        if (redir) begin
            if (tgt_misalign && i_stall) begin
                if_vld_d   = 1'b0;
                if_insn_d  = NOP_INSN;
                buf_vld_d  = 1'b1;
                buf_pc_d   = target;
                buf_insn_d = NOP_INSN;
            end else if (tgt_misalign) begin
                if_vld_d  = 1'b1;
                if_pc_d   = target;
                if_insn_d = NOP_INSN;
                buf_vld_d = 1'b0;
            end else begin
                if_vld_d  = 1'b0;
                if_insn_d = NOP_INSN;
                buf_vld_d = 1'b0;
            end
        end else if (i_stall) begin
            if (accept) begin
                buf_vld_d  = 1'b1;
                buf_pc_d   = pc_q;
                buf_insn_d = bus.rdata;
            end
        end else if (buf_vld_q) begin
            if_vld_d  = 1'b1;
            if_pc_d   = buf_pc_q;
            if_insn_d = buf_insn_q;
            buf_vld_d = 1'b0;
        end else if (accept) begin
            if_vld_d  = 1'b1;
            if_pc_d   = pc_q;
            if_insn_d = bus.rdata;
        end else begin
            if_vld_d = 1'b0;
        end
    end

    // NOTE: the one-entry buffer payload is reset too; it is a single register, not a RAM.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            buf_vld_q  <= 1'b0;
            buf_pc_q   <= RESET_PC;
            buf_insn_q <= NOP_INSN;
            if_vld_q   <= 1'b0;
            if_pc_q    <= RESET_PC;
            if_insn_q  <= NOP_INSN;
        end else begin
            buf_vld_q  <= buf_vld_d;
            buf_pc_q   <= buf_pc_d;
            buf_insn_q <= buf_insn_d;
            if_vld_q   <= if_vld_d;
            if_pc_q    <= if_pc_d;
            if_insn_q  <= if_insn_d;
        end
    end

    assign o_if_vld  = if_vld_q;
    assign o_if_pc   = if_pc_q;
    assign o_if_insn = if_insn_q;

`ifdef IF_FETCH_MISALIGN_EN
    logic mis_q, mis_d;
    logic buf_mis_q, buf_mis_d;

    // Misalign flag travels with the presented/buffered entry and drops once nothing is presented.
    always_comb begin
        mis_d     = mis_q;
        buf_mis_d = buf_mis_q;
        if (redir) begin
            mis_d     = tgt_misalign && !i_stall;
            buf_mis_d = tgt_misalign && i_stall;
        end else if (i_stall) begin
            if (accept) buf_mis_d = 1'b0;
        end else if (buf_vld_q) begin
            mis_d = buf_mis_q;
        end else begin
            mis_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mis_q     <= 1'b0;
            buf_mis_q <= 1'b0;
        end else begin
            mis_q     <= mis_d;
            buf_mis_q <= buf_mis_d;
        end
    end

    assign o_if_misalign = mis_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: fetch stream, stall buffering, redirects, PC wrap, misaligned targets.
// Inputs change 1ns after the rising edge and outputs are checked there, away from the edge.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] br_addr;
    logic        cl;
    logic [31:0] cl_addr;
    logic        halt;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] insn;
`ifdef IF_FETCH_MISALIGN_EN
    logic        misalign;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    if_fetch_unit_if bus ();

    if_fetch_unit dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_stall          (stall),
        .i_x_branch_taken (br),
        .i_x_branch_addr  (br_addr),
        .i_clint_assert   (cl),
        .i_clint_int_addr (cl_addr),
        .bus              (bus),
        .o_bus_if_halt    (halt),
        .o_if_vld         (vld),
        .o_if_pc          (pc),
`ifdef IF_FETCH_MISALIGN_EN
        .o_if_misalign    (misalign),
`endif
        .o_if_insn        (insn)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; br = 1'b0; br_addr = '0; cl = 1'b0; cl_addr = '0;
        bus.gnt = 1'b0; bus.rvld = 1'b0; bus.rdata = '0;
        tick(); tick();
        check("rst_req",  bus.req,  32'd0);
        check("rst_addr", bus.addr, 32'h0);
        check("rst_vld",  vld,      32'd0);
        check("rst_pc",   pc,       32'h0);
        check("rst_insn", insn,     32'h0000_0013);
        check("rst_halt", halt,     32'd0);
        rst = 1'b0;

        // Straight-line fetch: gnt same cycle as req, rvld the cycle after.
        tick();
        check("req0",      bus.req,  32'd1);
        check("addr0",     bus.addr, 32'h0);
        check("halt_req",  halt,     32'd1);
        bus.gnt = 1'b1; tick();
        check("halt_wait", halt,     32'd1);
        check("req_wait",  bus.req,  32'd0);
        bus.gnt = 1'b0; bus.rvld = 1'b1; bus.rdata = 32'h0050_0093; #1;
        check("halt_rvld", halt,     32'd0);
        tick();
        check("vld0",  vld,      32'd1);
        check("pc0",   pc,       32'h0);
        check("insn0", insn,     32'h0050_0093);
        check("addr4", bus.addr, 32'h4);
        check("req4",  bus.req,  32'd1);
        bus.rvld = 1'b0; bus.gnt = 1'b1; tick();
        check("vld_gap", vld, 32'd0);
        bus.gnt = 1'b0; bus.rvld = 1'b1; bus.rdata = 32'h2222_2222; tick();
        check("pc4",   pc,       32'h4);
        check("insn4", insn,     32'h2222_2222);
        check("addr8", bus.addr, 32'h8);

        // Stall while the 0x8 response returns: buffered, outputs hold.
        bus.rvld = 1'b0; bus.gnt = 1'b1; tick();
        bus.gnt = 1'b0; bus.rvld = 1'b1; bus.rdata = 32'h1111_1111; stall = 1'b1; tick();
        check("stall_req",  bus.req, 32'd0);
        check("stall_vld",  vld,     32'd0);
        check("stall_pc",   pc,      32'h4);
        check("stall_insn", insn,    32'h2222_2222);
        bus.rvld = 1'b0; tick();
        check("stall_hold_req", bus.req, 32'd0);
        check("stall_halt",     halt,    32'd0);
        stall = 1'b0; tick();
        check("buf_vld",  vld,     32'd1);
        check("buf_pc",   pc,      32'h8);
        check("buf_insn", insn,    32'h1111_1111);
        check("buf_req",  bus.req, 32'd0);
        tick();
        check("reqC",  bus.req,  32'd1);
        check("addrC", bus.addr, 32'hC);

        // Branch while in WAIT: stale response dropped.
        bus.gnt = 1'b1; tick();
        bus.gnt = 1'b0; br = 1'b1; br_addr = 32'h100; tick();
        br = 1'b0;
        check("kill_req",  bus.req, 32'd0);
        check("kill_halt", halt,    32'd1);
        check("kill_vld",  vld,     32'd0);
        bus.rvld = 1'b1; bus.rdata = 32'hDEAD_BEEF; tick();
        bus.rvld = 1'b0;
        check("stale_vld", vld,      32'd0);
        check("req100",    bus.req,  32'd1);
        check("addr100",   bus.addr, 32'h100);
        bus.gnt = 1'b1; tick();
        check("vld_pre100", vld, 32'd0);
        bus.gnt = 1'b0; bus.rvld = 1'b1; bus.rdata = 32'h3333_3333; tick();
        bus.rvld = 1'b0;
        check("pc100",   pc,       32'h100);
        check("insn100", insn,     32'h3333_3333);
        check("vld100",  vld,      32'd1);
        check("addr104", bus.addr, 32'h104);

        // Trap and branch together: trap wins.
        cl = 1'b1; cl_addr = 32'h80; br = 1'b1; br_addr = 32'h200; tick();
        cl = 1'b0; br = 1'b0;
        check("prio_addr", bus.addr, 32'h80);
        check("prio_req",  bus.req,  32'd1);
        check("prio_vld",  vld,      32'd0);

        // PC wrap at the top of the address space.
        br = 1'b1; br_addr = 32'hFFFF_FFFC; bus.gnt = 1'b1; tick();
        br = 1'b0; bus.gnt = 1'b0;
        check("kill2_req",  bus.req, 32'd0);
        check("kill2_halt", halt,    32'd1);
        bus.rvld = 1'b1; tick();
        bus.rvld = 1'b0;
        check("addr_top", bus.addr, 32'hFFFF_FFFC);
        bus.gnt = 1'b1; tick();
        bus.gnt = 1'b0; bus.rvld = 1'b1; bus.rdata = 32'h4444_4444; tick();
        bus.rvld = 1'b0;
        check("pc_top",   pc,       32'hFFFF_FFFC);
        check("insn_top", insn,     32'h4444_4444);
        check("addr_wrap", bus.addr, 32'h0);

        // Misaligned branch target.
        br = 1'b1; br_addr = 32'h102; tick();
        br = 1'b0;
`ifdef IF_FETCH_MISALIGN_EN
        check("mis_req",  bus.req,  32'd0);
        check("mis_halt", halt,     32'd0);
        check("mis_vld",  vld,      32'd1);
        check("mis_flag", misalign, 32'd1);
        check("mis_pc",   pc,       32'h102);
        check("mis_insn", insn,     32'h0000_0013);
        tick();
        check("mis_park_req", bus.req, 32'd0);
`else
        check("align_req",  bus.req,  32'd1);
        check("align_addr", bus.addr, 32'h100);
        check("align_vld",  vld,      32'd0);
        bus.gnt = 1'b1; tick();
        bus.gnt = 1'b0;
`endif

        // Reset mid-flight; a late response must be ignored.
        #1 rst = 1'b1;
        #1;
        check("rst2_req",  bus.req,  32'd0);
        check("rst2_addr", bus.addr, 32'h0);
        check("rst2_vld",  vld,      32'd0);
        check("rst2_halt", halt,     32'd0);
        rst = 1'b0; bus.rvld = 1'b1; bus.rdata = 32'h5555_5555; tick();
        bus.rvld = 1'b0;
        check("late_vld",  vld,      32'd0);
        check("late_req",  bus.req,  32'd1);
        check("late_addr", bus.addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
